// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package uart_loader_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;

    // Width needed to count up to timeout_bits * clks_per_bit idle cycles.
    function automatic int tmo_cnt_width(input int timeout_bits, input int clks_per_bit);
        return $clog2(timeout_bits * clks_per_bit + 1);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, framing FSM, registered byte/valid
// and a one-cycle framing-error pulse. The line is sampled near mid-bit.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_valid_o,
    output logic              frame_err_o,
    output logic              idle_o
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic              sync1_q, sync2_q;
    rx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              rxs;

    assign rxs          = sync2_q;
    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign idle_o       = (state_q == RX_IDLE);

    // Next-state logic of the framing FSM; valid/error are single-cycle pulses.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!rxs) state_d = RX_START;
                else      state_d = RX_IDLE;
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    if (!rxs) state_d = RX_DATA;
                    else      state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[BYTE_W-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               state_d = RX_DATA;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rxs) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Synchronizer and FSM registers; the synchronizer idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Packs received UART bytes little-endian into 32-bit words and issues one
// write strobe per word to the instruction-memory programming port.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          TIMEOUT_BITS = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic        rx,
    output logic        memcon_prog_ena,
    output logic [31:0] uart_dout,
    output logic        imem_prog_we,
    output logic [31:0] imem_prog_addr,
    output logic [15:0] word_count,
    output logic        frame_err
);

    localparam int            TW       = tmo_cnt_width(TIMEOUT_BITS, CLKS_PER_BIT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam int            PART_W   = BYTE_W * (WORD_BYTES - 1);

    logic [BYTE_W-1:0] rx_byte_s;
    logic              rx_valid_s, rx_ferr_s, rx_idle_s;

    logic              ena_q, ena_d;
    logic [31:0]       dout_q, dout_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ferr_q, ferr_d;
    logic [1:0]        k_q, k_d;
    logic [PART_W-1:0] part_q, part_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              rise_s, fall_s, accept_s;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i        (clk),
        .rst_i        (Rst),
        .rx_i         (rx),
        .byte_o       (rx_byte_s),
        .byte_valid_o (rx_valid_s),
        .frame_err_o  (rx_ferr_s),
        .idle_o       (rx_idle_s)
    );

    assign memcon_prog_ena = ena_q;
    assign uart_dout       = dout_q;
    assign imem_prog_we    = we_q;
    assign imem_prog_addr  = addr_q;
    assign word_count      = cnt_q;
    assign frame_err       = ferr_q;

    // A byte arriving on the cycle the session closes is dropped.
    assign rise_s   = prog && !ena_q;
    assign fall_s   = !prog && ena_q;
    assign accept_s = rx_valid_s && ena_q && prog;

    // Assembler, address/count bookkeeping, timeout and session edges;
    // later assignments take priority (session rise wins over everything).
    always_comb begin
        ena_d  = prog;
        dout_d = dout_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        ferr_d = ferr_q;
        k_d    = k_q;
        part_d = part_q;
        tmo_d  = tmo_q;

        // Address and count advance the cycle after the strobe.
        if (we_q) begin
            addr_d = addr_q + 32'd4;
            cnt_d  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end else begin
            addr_d = addr_q;
        end

        if (rx_ferr_s) ferr_d = 1'b1;
        else           ferr_d = ferr_q;

        // Partial-word timeout only counts while the line is idle.
        if (k_q == 2'd0 || accept_s) begin
            tmo_d = '0;
        end else if (rx_idle_s) begin
            if (tmo_q == TMO_LAST) begin
                tmo_d = '0;
                k_d   = 2'd0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = tmo_q;
        end

        if (accept_s) begin
            case (k_q)
                2'd3: begin
                    dout_d = {rx_byte_s, part_q};
                    we_d   = 1'b1;
                    k_d    = 2'd0;
                end
                default: begin
                    part_d[{k_q, 3'b000} +: BYTE_W] = rx_byte_s;
                    k_d = k_q + 2'd1;
                end
            endcase
        end else begin
            part_d = part_q;
        end

        if (fall_s) begin
            k_d   = 2'd0;
            tmo_d = '0;
        end else begin
            ena_d = prog;
        end

        if (rise_s) begin
            ferr_d = 1'b0;
            cnt_d  = 16'd0;
            k_d    = 2'd0;
            tmo_d  = '0;
            addr_d = BASE_ADDR;
        end else begin
            ena_d = prog;
        end
    end

    // Loader state registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            ena_q  <= 1'b0;
            dout_q <= 32'd0;
            we_q   <= 1'b0;
            addr_q <= BASE_ADDR;
            cnt_q  <= 16'd0;
            ferr_q <= 1'b0;
            k_q    <= 2'd0;
            part_q <= '0;
            tmo_q  <= '0;
        end else begin
            ena_q  <= ena_d;
            dout_q <= dout_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            ferr_q <= ferr_d;
            k_q    <= k_d;
            part_q <= part_d;
            tmo_q  <= tmo_d;
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench: drives 8N1 frames and compares strobes and session
// outputs against a queue-based word model.
module tb_uart_imem_loader;

    localparam int          CPB  = 8;
    localparam int          TOB  = 6;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        prog = 1'b0;
    logic        rx = 1'b1;
    logic        memcon_prog_ena;
    logic [31:0] uart_dout;
    logic        imem_prog_we;
    logic [31:0] imem_prog_addr;
    logic [15:0] word_count;
    logic        frame_err;

    uart_imem_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB), .BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .Rst             (Rst),
        .prog            (prog),
        .rx              (rx),
        .memcon_prog_ena (memcon_prog_ena),
        .uart_dout       (uart_dout),
        .imem_prog_we    (imem_prog_we),
        .imem_prog_addr  (imem_prog_addr),
        .word_count      (word_count),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        eq[$];
    logic [7:0]  part[$];
    logic [31:0] m_addr = BASE;
    logic [15:0] m_cnt = 16'd0;
    logic        m_ferr = 1'b0;
    logic        m_sess = 1'b0;
    logic [31:0] exp_hold = 32'd0;
    logic        we_prev = 1'b0;
    exp_t        e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference behaviour for one received frame.
    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ferr = 1'b1;
        end else if (m_sess) begin
            part.push_back(b);
            if (part.size() == 4) begin
                eq.push_back('{w: {part[3], part[2], part[1], part[0]}, a: m_addr});
                m_addr = m_addr + 32'd4;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                part.delete();
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = good;
        tick(CPB);
        model_byte(b, good);
        rx = 1'b1;
        tick(CPB / 2 + int'($urandom_range(0, CPB)));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_frame(w[8*i +: 8], 1'b1);
    endtask

    task automatic set_prog(input logic v);
        if (v && !m_sess) begin
            m_addr = BASE;
            m_cnt  = 16'd0;
            m_ferr = 1'b0;
            part.delete();
        end
        if (!v) part.delete();
        prog   = v;
        m_sess = v;
        tick(3);
        chk("prog_ena", memcon_prog_ena, v);
    endtask

    task automatic check_state(input string tag);
        tick(4);
        chk({tag, "_addr"}, imem_prog_addr, m_addr);
        chk({tag, "_count"}, word_count, m_cnt);
        chk({tag, "_ferr"}, frame_err, m_ferr);
        chk({tag, "_pending"}, 32'(eq.size()), 32'd0);
    endtask

    // Strobe monitor: data/address against the model, spacing and hold.
    always @(negedge clk) begin
        if (!Rst) begin
            if (imem_prog_we) begin
                if (we_prev) chk("we_back_to_back", 32'(we_prev), 32'd0);
                if (eq.size() == 0) begin
                    chk("we_spurious", 32'(imem_prog_we), 32'd0);
                end else begin
                    e = eq.pop_front();
                    chk("strobe_data", uart_dout, e.w);
                    chk("strobe_addr", imem_prog_addr, e.a);
                    exp_hold = e.w;
                end
            end else begin
                chk("dout_hold", uart_dout, exp_hold);
            end
        end
        we_prev = imem_prog_we;
    end

    initial begin
        logic [31:0] w;
        tick(3);
        Rst = 1'b0;
        tick(2);
        chk("rst_ena", memcon_prog_ena, 1'b0);
        chk("rst_dout", uart_dout, 32'd0);
        chk("rst_we", imem_prog_we, 1'b0);
        chk("rst_addr", imem_prog_addr, BASE);
        chk("rst_count", word_count, 16'd0);
        chk("rst_ferr", frame_err, 1'b0);

        // Reset in the middle of a frame, then a clean session.
        set_prog(1'b1);
        send_frame(8'hA5, 1'b1);
        rx = 1'b0;
        tick(3 * CPB);
        Rst = 1'b1;
        rx = 1'b1;
        prog = 1'b0;
        exp_hold = 32'd0;
        tick(3);
        Rst = 1'b0;
        m_sess = 1'b0;
        m_addr = BASE;
        m_cnt = 16'd0;
        m_ferr = 1'b0;
        part.delete();
        tick(2 * CPB);
        chk("rst2_addr", imem_prog_addr, BASE);
        chk("rst2_dout", uart_dout, 32'd0);
        chk("rst2_ferr", frame_err, 1'b0);

        // Single word, then two more words wrapping the address.
        set_prog(1'b1);
        send_word(32'h1234_5678);
        check_state("single");
        send_word(32'hDEAD_BEEF);
        send_word(32'h0000_0001);
        check_state("multi_wrap");

        // Bad stop bit in the middle of a word keeps the byte index.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h99, 1'b0);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        check_state("frame_err");

        // Short low glitch inside a word must not produce a byte.
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        rx = 1'b0;
        tick(CPB / 4);
        rx = 1'b1;
        tick(CPB);
        send_frame(8'h04, 1'b1);
        check_state("glitch");

        // Session abort after two bytes, then a fresh session.
        send_frame(8'hAA, 1'b1);
        send_frame(8'hBB, 1'b1);
        set_prog(1'b0);
        check_state("abort_hold");
        set_prog(1'b1);
        send_word(32'hCAFE_F00D);
        check_state("restart");

        // Timeout discards a partial word.
        send_frame(8'h55, 1'b1);
        send_frame(8'h66, 1'b1);
        tick((TOB + 1) * CPB);
        part.delete();
        send_word(32'h0BAD_C0DE);
        check_state("timeout");

        // Randomized words with occasional framing errors.
        for (int n = 0; n < 6; n++) begin
            w = $urandom;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) send_frame(8'($urandom), 1'b0);
                send_frame(w[8*i +: 8], 1'b1);
            end
        end
        check_state("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
